// File: rtl/sdram_responder_pkg.sv
// Shared types and width helpers for the SDRAM responder memory model.
package sdram_responder_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LAT,
        BURST,
        REFRESH
    } rd_state_t;

    function automatic int xwidth(input int bankbits, input int rowbits, input int colbits);
        return bankbits + rowbits + colbits;
    endfunction

    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/sdram_responder_bram.sv
// Simple dual-port block RAM: one write port, one registered read-first read port.
module bram_1r1w #(
    parameter int AW = 12,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [0:(2**AW)-1];

    // Same-edge read of a location being written returns the old contents.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/sdram_responder.sv
// Block-RAM stand-in for the SDRAM controller's request interface: burst reads with
// fixed latency, single-word writes, optional refresh stalls and single-bit error injection.
module sdram_responder
    import sdram_responder_pkg::*;
#(
    parameter int BANKBITS       = 1,
    parameter int ROWBITS        = 11,
    parameter int COLBITS        = 8,
    parameter int DWIDTH         = 16,
    parameter int MEMBITS        = 12,
    parameter int RD_LAT         = 4,
    parameter int REFRESH_PERIOD = 0,
    parameter int REFRESH_LEN    = 8,
    localparam int XWIDTH        = xwidth(BANKBITS, ROWBITS, COLBITS)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [XWIDTH-1:0] rd_addr,
    input  logic [3:0]        rd_len,
    input  logic              rd_req,
    output logic              rd_ack,
    output logic [DWIDTH-1:0] rd_data,
    output logic              rd_rdy,
    input  logic [XWIDTH-1:0] wr_addr,
    input  logic [DWIDTH-1:0] wr_data,
    input  logic [3:0]        wr_len,
    input  logic              wr_req,
    output logic              wr_ack,
    input  logic              inject
);

    localparam int              RCW          = cnt_width(REFRESH_PERIOD);
    localparam logic [RCW-1:0]  REF_RELOAD   = RCW'(REFRESH_PERIOD);
    localparam logic [3:0]      LAT_INIT     = 4'(RD_LAT - 2);
    localparam logic [7:0]      REF_LEN_INIT = 8'(REFRESH_LEN - 1);

    rd_state_t         state;
    logic [3:0]        lat_cnt;
    logic [3:0]        burst_rem;
    logic [7:0]        ref_len_cnt;
    logic [RCW-1:0]    ref_cnt;
    logic              ref_pending;
    logic              issued;
    logic              inj_flag;
    logic [XWIDTH-1:0] rd_ptr;
    logic [DWIDTH-1:0] ram_q;
    logic              ref_block;
    logic              rd_fire;
    logic              wr_fire;
    logic              issue;
    logic              ram_we;
    logic              unused_inputs;

    always_comb begin
        ref_block     = ref_pending || (state == REFRESH);
        rd_fire       = (state == IDLE) && rd_req && !rd_ack && !ref_block;
        wr_fire       = wr_req && !wr_ack && !ref_block;
        issue         = (state == BURST) || ((state == LAT) && (lat_cnt == '0));
        ram_we        = wr_fire && reset_n;
        unused_inputs = ^{wr_len, wr_addr[XWIDTH-1:MEMBITS]};
    end

    // RAM read is issued one cycle before rd_rdy; 'issued' marks the word arriving on ram_q.
    bram_1r1w #(
        .AW (MEMBITS),
        .DW (DWIDTH)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (wr_addr[MEMBITS-1:0]),
        .wdata (wr_data),
        .re    (issue),
        .raddr (rd_ptr[MEMBITS-1:0]),
        .rdata (ram_q)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= IDLE;
            rd_ack      <= 1'b0;
            wr_ack      <= 1'b0;
            rd_rdy      <= 1'b0;
            rd_data     <= '0;
            issued      <= 1'b0;
            inj_flag    <= 1'b0;
            ref_pending <= 1'b0;
            ref_cnt     <= REF_RELOAD;
            ref_len_cnt <= '0;
            lat_cnt     <= '0;
            burst_rem   <= '0;
            rd_ptr      <= '0;
        end else begin
            rd_ack <= rd_fire;
            wr_ack <= wr_fire;
            issued <= issue;
            rd_rdy <= issued;

            if (issued) begin
                rd_data  <= ram_q ^ DWIDTH'(inj_flag);
                inj_flag <= inject;
            end else if (inject) begin
                inj_flag <= 1'b1;
            end

            if ((REFRESH_PERIOD != 0) && !ref_pending && (state != REFRESH)) begin
                if (ref_cnt == '0) ref_pending <= 1'b1;
                else               ref_cnt     <= ref_cnt - RCW'(1);
            end

            case (state)
                IDLE: begin
                    if (ref_pending) begin
                        state       <= REFRESH;
                        ref_pending <= 1'b0;
                        ref_len_cnt <= REF_LEN_INIT;
                    end else if (rd_fire) begin
                        state     <= LAT;
                        rd_ptr    <= rd_addr;
                        burst_rem <= rd_len;
                        lat_cnt   <= LAT_INIT;
                    end
                end
                LAT: begin
                    if (lat_cnt == '0) begin
                        rd_ptr <= rd_ptr + XWIDTH'(1);
                        state  <= (burst_rem == '0) ? IDLE : BURST;
                    end else begin
                        lat_cnt <= lat_cnt - 4'd1;
                    end
                end
                BURST: begin
                    rd_ptr    <= rd_ptr + XWIDTH'(1);
                    burst_rem <= burst_rem - 4'd1;
                    if (burst_rem == 4'd1) state <= IDLE;
                end
                REFRESH: begin
                    if (ref_len_cnt == '0) begin
                        state   <= IDLE;
                        ref_cnt <= REF_RELOAD;
                    end else begin
                        ref_len_cnt <= ref_len_cnt - 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_responder.sv
// Directed and randomized checks of sdram_responder against a word-array memory model.
module tb_sdram_responder;

    localparam int RD_LAT      = 4;
    localparam int REFRESH_LEN = 8;
    localparam int MEMBITS     = 12;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [19:0] rd_addr;
    logic [3:0]  rd_len;
    logic        rd_req;
    logic        rd_ack;
    logic [15:0] rd_data;
    logic        rd_rdy;
    logic [19:0] wr_addr;
    logic [15:0] wr_data;
    logic [3:0]  wr_len;
    logic        wr_req;
    logic        wr_ack;
    logic        inject;

    logic [15:0] model [0:(2**MEMBITS)-1];
    int n_assert = 0;
    int n_fail   = 0;

    sdram_responder #(
        .BANKBITS       (1),
        .ROWBITS        (11),
        .COLBITS        (8),
        .DWIDTH         (16),
        .MEMBITS        (MEMBITS),
        .RD_LAT         (RD_LAT),
        .REFRESH_PERIOD (100),
        .REFRESH_LEN    (REFRESH_LEN)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .rd_addr (rd_addr),
        .rd_len  (rd_len),
        .rd_req  (rd_req),
        .rd_ack  (rd_ack),
        .rd_data (rd_data),
        .rd_rdy  (rd_rdy),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .wr_len  (wr_len),
        .wr_req  (wr_req),
        .wr_ack  (wr_ack),
        .inject  (inject)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [19:0] a, input logic [15:0] d);
        int unsigned w;
        logic [19:0] aa;
        w = 0;
        aa = a;
        wr_addr = a;
        wr_data = d;
        wr_len  = 4'($urandom);
        wr_req  = 1'b1;
        do begin
            tick();
            w++;
        end while (!wr_ack && w < 64);
        check("wr_ack_seen", 32'(wr_ack), 1);
        if (wr_ack) model[aa[MEMBITS-1:0]] = d;
        tick();
        check("wr_ack_single", 32'(wr_ack), 0);
        wr_req = 1'b0;
    endtask

    // Expected word k of a burst is model[(a + k) mod 2**MEMBITS], arriving RD_LAT cycles after rd_ack.
    task automatic read_check(input logic [19:0] a, input logic [3:0] len, input logic [15:0] inj0,
                              input bit with_wr, input logic [19:0] wa_in, input logic [15:0] wd_in);
        int unsigned w;
        logic [19:0] wa;
        logic [15:0] exp;
        w = 0;
        rd_addr = a;
        rd_len  = len;
        rd_req  = 1'b1;
        if (with_wr) begin
            wr_addr = wa_in;
            wr_data = wd_in;
            wr_req  = 1'b1;
        end
        do begin
            tick();
            w++;
        end while (!rd_ack && !wr_ack && w < 64);
        check("rd_ack_seen", 32'(rd_ack), 1);
        if (with_wr) begin
            check("wr_ack_same_cycle", 32'(wr_ack), 1);
            if (wr_ack) model[wa_in[MEMBITS-1:0]] = wd_in;
        end
        if (rd_ack !== 1'b1) begin
            rd_req = 1'b0;
            wr_req = 1'b0;
            return;
        end
        for (int k = 1; k <= RD_LAT + int'(len) + 2; k++) begin
            tick();
            if (k == 1) begin
                check("rd_ack_single", 32'(rd_ack), 0);
                rd_req = 1'b0;
                if (with_wr) begin
                    check("wr_ack_single", 32'(wr_ack), 0);
                    wr_req = 1'b0;
                end
            end
            if (k >= RD_LAT && k <= RD_LAT + int'(len)) begin
                check("rd_rdy_burst", 32'(rd_rdy), 1);
                wa  = a + 20'(k - RD_LAT);
                exp = model[wa[MEMBITS-1:0]] ^ ((k == RD_LAT) ? inj0 : 16'h0000);
                check("rd_data", 32'(rd_data), 32'(exp));
            end else begin
                check("rd_rdy_idle", 32'(rd_rdy), 0);
            end
        end
    endtask

    initial begin
        logic [19:0] base;
        logic [3:0]  blen;
        int unsigned w;
        int          cnt;
        int          last;
        int          gap;
        int          gaps_long;
        int          max_gap;
        int          acks;
        logic        prev_ack;
        logic [15:0] inj;

        reset_n = 1'b0;
        rd_addr = '0;
        rd_len  = '0;
        rd_req  = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        wr_len  = '0;
        wr_req  = 1'b0;
        inject  = 1'b0;
        repeat (3) tick();
        check("rst_rd_ack", 32'(rd_ack), 0);
        check("rst_wr_ack", 32'(wr_ack), 0);
        check("rst_rd_rdy", 32'(rd_rdy), 0);
        check("rst_rd_data", 32'(rd_data), 0);
        reset_n = 1'b1;
        tick();

        // Single word, exact latency
        do_write(20'h00010, 16'hA5A5);
        read_check(20'h00010, 4'd0, 16'h0, 1'b0, '0, '0);

        // 16-word burst straddling a row boundary
        for (int i = 0; i < 16; i++) do_write(20'h003F8 + 20'(i), 16'(i));
        read_check(20'h003F8, 4'd15, 16'h0, 1'b0, '0, '0);

        // Address wrap at the top of the XWIDTH space
        do_write(20'hFFFFE, 16'd1);
        do_write(20'hFFFFF, 16'd2);
        do_write(20'h00000, 16'd3);
        do_write(20'h00001, 16'd4);
        read_check(20'hFFFFE, 4'd3, 16'h0, 1'b0, '0, '0);

        // Simultaneous read and write; write lands inside the burst it races with
        read_check(20'hFFFFE, 4'd3, 16'h0, 1'b1, 20'hFFFFF, 16'h00BB);

        // Error injection consumed by exactly one word
        do_write(20'h00123, 16'h1234);
        inject = 1'b1;
        tick();
        inject = 1'b0;
        read_check(20'h00123, 4'd0, 16'h0001, 1'b0, '0, '0);
        read_check(20'h00123, 4'd0, 16'h0000, 1'b0, '0, '0);

        // Randomized bursts over the whole address space
        for (int it = 0; it < 20; it++) begin
            base = 20'($urandom);
            blen = 4'($urandom_range(0, 15));
            for (int i = 0; i <= int'(blen); i++) do_write(base + 20'(i), 16'($urandom));
            inj = 16'h0;
            if ($urandom_range(0, 3) == 0) begin
                inject = 1'b1;
                tick();
                inject = 1'b0;
                inj = 16'h0001;
            end
            read_check(base, blen, inj, 1'b0, '0, '0);
        end

        // Continuous write requests across refresh windows
        base      = 20'h00800;
        last      = -1;
        gaps_long = 0;
        max_gap   = 0;
        acks      = 0;
        prev_ack  = 1'b0;
        wr_addr   = base;
        wr_data   = 16'($urandom);
        wr_req    = 1'b1;
        for (int c = 0; c < 330; c++) begin
            tick();
            if (wr_ack) begin
                check("wr_ack_no_repeat", 32'(prev_ack), 0);
                model[wr_addr[MEMBITS-1:0]] = wr_data;
                if (last >= 0) begin
                    gap = c - last - 1;
                    if (gap >= REFRESH_LEN) gaps_long++;
                    if (gap > max_gap) max_gap = gap;
                end
                last = c;
                acks++;
                wr_addr = wr_addr + 20'd1;
                wr_data = 16'($urandom);
            end
            prev_ack = wr_ack;
        end
        wr_req = 1'b0;
        check("refresh_windows_seen", 32'(gaps_long >= 2), 1);
        check("refresh_gap_bounded", 32'(max_gap <= REFRESH_LEN + 4), 1);
        check("refresh_ack_rate", 32'(acks >= 120), 1);
        for (int b = 0; b < acks; b += 16) begin
            blen = (acks - b >= 16) ? 4'd15 : 4'(acks - b - 1);
            read_check(base + 20'(b), blen, 16'h0, 1'b0, '0, '0);
        end

        // Reset in the middle of a burst
        base = 20'h00A00;
        for (int i = 0; i < 16; i++) do_write(base + 20'(i), 16'($urandom));
        rd_addr = base;
        rd_len  = 4'd15;
        rd_req  = 1'b1;
        w = 0;
        do begin
            tick();
            w++;
        end while (!rd_ack && w < 64);
        check("mid_rst_rd_ack", 32'(rd_ack), 1);
        tick();
        rd_req = 1'b0;
        cnt = 0;
        w = 0;
        while (cnt < 5 && w < 64) begin
            tick();
            w++;
            if (rd_rdy) begin
                check("mid_rst_data", 32'(rd_data), 32'(model[10'(cnt) + 12'hA00]));
                cnt++;
            end
        end
        check("mid_rst_words_before", 32'(cnt), 5);
        reset_n = 1'b0;
        tick();
        check("mid_rst_rd_rdy", 32'(rd_rdy), 0);
        check("mid_rst_rd_data", 32'(rd_data), 0);
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            check("post_rst_rd_rdy", 32'(rd_rdy), 0);
        end
        read_check(base, 4'd15, 16'h0, 1'b0, '0, '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
